// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the sequencer state encoding, slice width and iteration-count helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-carry adder slice built from per-bit full adders.
// The top reuses one instance for every nibble iteration.
module nibble_add_slice
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s4,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
      assign s4[gi]   = a4[gi] ^ b4[gi] ^ c[gi];
      assign c[gi+1]  = (a4[gi] & b4[gi]) | (c[gi] & (a4[gi] ^ b4[gi]));
    end
  endgenerate

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer adding two WIDTH-bit operands one nibble per clock through a single
// shared 4-bit slice, LSB nibble first, with valid/ready on both sides.
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int SH_W  = (WIDTH > 4) ? $clog2(WIDTH) : 2;

  state_t              state_reg;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic                carry_reg;
  logic [IDX_W-1:0]    idx_reg;

  logic [SH_W-1:0]     nib_lsb;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;

  // Bit position of the nibble currently being processed.
  assign nib_lsb = SH_W'(idx_reg) * SH_W'(NIBBLE_W);
  assign slice_a = a_reg[nib_lsb +: NIBBLE_W];
  assign slice_b = b_reg[nib_lsb +: NIBBLE_W];

  nibble_add_slice u_slice (
    .a4 (slice_a),
    .b4 (slice_b),
    .ci (carry_reg),
    .s4 (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum[nib_lsb +: NIBBLE_W] <= slice_s;
          carry_reg                <= slice_co;
          if (idx_reg == IDX_W'(NIB - 1)) begin
            cout      <= slice_co;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so no input reaches them combinationally.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

endmodule
